// File: rtl/mem_arbiter_if.sv
// Strobe/busy memory port: 1-cycle rstrb or wmask pulse,
// then the requester waits while rbusy/wbusy.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 24
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic [3:0]            wmask;
  logic                  rstrb;
  logic [31:0]           rdata;
  logic                  rbusy;
  logic                  wbusy;

  modport master (
    output addr,
    output wdata,
    output wmask,
    output rstrb,
    input  rdata,
    input  rbusy,
    input  wbusy
  );

  modport slave (
    input  addr,
    input  wdata,
    input  wmask,
    input  rstrb,
    output rdata,
    output rbusy,
    output wbusy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the shared memory/IO port.
// Uncontended accesses pass straight through; losers are latched and replayed.
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 24,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  m0,
  mem_arbiter_if.slave  m1,
  mem_arbiter_if.master s
);

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
    logic [3:0]            wmask;
    logic                  rd;
  } req_t;

  state_t                state_q, state_d;
  req_t                  pend_q [2];
  req_t                  pend_d [2];
  logic [1:0]            pvld_q, pvld_d;
  logic                  last_q, last_d;
  logic                  own_rd_q, own_rd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;

  req_t       live [2];
  logic [1:0] lreq;
  logic [1:0] blk;
  logic [1:0] lok;
  logic       owning;
  logic       owner;
  logic       done;
  logic       arb;
  logic       tie;
  logic       issue;
  logic       from_pend;
  logic       gnt;
  logic       go;
  req_t       src;

  always_comb begin
    live[0].addr  = m0.addr;
    live[0].wdata = m0.wdata;
    live[0].wmask = m0.wmask;
    live[0].rd    = (m0.wmask == 4'h0);
    live[1].addr  = m1.addr;
    live[1].wdata = m1.wdata;
    live[1].wmask = m1.wmask;
    live[1].rd    = (m1.wmask == 4'h0);
    lreq[0]       = m0.rstrb | (|m0.wmask);
    lreq[1]       = m1.rstrb | (|m1.wmask);
  end

  assign owning = (state_q != IDLE);
  assign owner  = (state_q == OWN1);
  assign done   = owning &
                  (own_rd_q ? ~s.rbusy : ~s.wbusy);
  assign arb    = ~owning | done;

  // A master with a slot or an unfinished access is ignored.
  assign blk[0] = pvld_q[0] |
                  (owning & ~owner & ~done);
  assign blk[1] = pvld_q[1] |
                  (owning & owner & ~done);
  assign lok    = lreq & ~blk;
  assign tie    = ROUND_ROBIN ? ~last_q : 1'b0;

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    pvld_d    = pvld_q;
    last_d    = last_q;
    own_rd_d  = own_rd_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    issue     = 1'b0;
    from_pend = 1'b0;
    gnt       = 1'b0;
    src       = live[0];

    if (arb && (|pvld_q)) begin
      issue     = 1'b1;
      from_pend = 1'b1;
      gnt       = (&pvld_q) ? tie : pvld_q[1];
      src       = pend_q[gnt];
    end else if (arb && (|lok)) begin
      issue = 1'b1;
      gnt   = (&lok) ? tie : lok[1];
      src   = live[gnt];
    end

    if (issue) begin
      state_d  = gnt ? OWN1 : OWN0;
      last_d   = gnt;
      own_rd_d = src.rd;
      addr_d   = src.addr;
      wdata_d  = src.wdata;
    end else if (done) begin
      state_d = IDLE;
    end

    if (from_pend) begin
      pvld_d[gnt] = 1'b0;
    end

    for (int i = 0; i < 2; i++) begin
      if (lok[i] &&
          !(issue && !from_pend && (gnt == i[0]))) begin
        pvld_d[i] = 1'b1;
        pend_d[i] = live[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pvld_q    <= 2'b00;
      pend_q[0] <= '0;
      pend_q[1] <= '0;
      last_q    <= 1'b1;
      own_rd_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      pvld_q    <= pvld_d;
      pend_q[0] <= pend_d[0];
      pend_q[1] <= pend_d[1];
      last_q    <= last_d;
      own_rd_q  <= own_rd_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign go      = reset & issue;
  assign s.addr  = go ? src.addr  : addr_q;
  assign s.wdata = go ? src.wdata : wdata_q;
  assign s.wmask = go ? src.wmask : 4'h0;
  assign s.rstrb = go & src.rd;

  assign m0.rdata = s.rdata;
  assign m1.rdata = s.rdata;

  assign m0.rbusy = reset &
    ((pvld_q[0] & pend_q[0].rd) |
     (owning & ~owner & own_rd_q & ~done));
  assign m0.wbusy = reset &
    ((pvld_q[0] & ~pend_q[0].rd) |
     (owning & ~owner & ~own_rd_q & ~done));
  assign m1.rbusy = reset &
    ((pvld_q[1] & pend_q[1].rd) |
     (owning & owner & own_rd_q & ~done));
  assign m1.wbusy = reset &
    ((pvld_q[1] & ~pend_q[1].rd) |
     (owning & owner & ~own_rd_q & ~done));

endmodule
